dllp_receive: RTL and testbench

Receive-side data link layer for the PCIe datalink path; the counterpart of the transmit path's sequence-number/LCRC framing and retry logic. Accepts framed TLPs (sequence header, TLP DWs, LCRC) on an AXI-stream from the physical layer and checks LCRC and sequence number. Forwards only good, in-order TLPs to the transaction layer through a store-and-forward buffer. Emits the ack/nak indication that the local transmitter consumes as `ack_nack_i`/`ack_nack_vld_i`/`ack_seq_num_i`.

---
 rtl/dllp_receive.sv | 275 +++++++++++++++++++++++++++
 tb/tb_dllp_receive.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dllp_receive.sv
`default_nettype none
// ============================================================================
// dllp_receive : PCIe data link receive path - LCRC/sequence check, ACK/NAK
//                generation and store-and-forward TLP buffer.   Rev 1.0
// ============================================================================
module dllp_receive #(
  parameter int DATA_WIDTH   = 32,
  parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int USER_WIDTH   = 1,
  parameter int BUFFER_DEPTH = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  ack_nack_o,
  output logic                  ack_nack_vld_o,
  output logic [11:0]           ack_seq_num_o,
  output logic                  crc_err_o,
  output logic                  seq_err_o
);

  localparam int              AW            = $clog2(BUFFER_DEPTH);
  localparam int              PW            = AW + 1;
  localparam logic [PW-1:0]   USED_MAX      = PW'(BUFFER_DEPTH - 2);
  localparam logic [31:0]     CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0]     CRC_INIT      = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {ST_HDR = 1'b0, ST_DATA = 1'b1} state_t;

  // Reflected CRC-32 over the lowest nbytes bytes of data, byte 0 first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc_in,
                                           input logic [DATA_WIDTH-1:0] data,
                                           input int nbytes);
    logic [31:0] c;
    c = crc_in;
    for (int b = 0; b < KEEP_WIDTH; b++) begin
      if (b < nbytes) begin
        c = c ^ {24'd0, data[8*b +: 8]};
        for (int i = 0; i < 8; i++) begin
          c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  state_t                state_q, state_d;
  logic [11:0]           seq_q, seq_d;
  logic [11:0]           next_seq_q, next_seq_d;
  logic                  nak_sched_q, nak_sched_d;
  logic [31:0]           crc_q, crc_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  tready_q, tready_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_last_q, m_last_d;
  logic                  ack_q, ack_d;
  logic                  ack_vld_q, ack_vld_d;
  logic [11:0]           ack_seq_q, ack_seq_d;
  logic                  crc_err_q, crc_err_d;
  logic                  seq_err_q, seq_err_d;

  logic [DATA_WIDTH:0]   mem [BUFFER_DEPTH];
  logic                  wr_en;
  logic [DATA_WIDTH:0]   wr_word;
  logic [DATA_WIDTH:0]   rd_word;
  logic                  accept;
  logic                  frame_end;
  logic                  frame_malformed;
  logic                  frame_user;
  logic                  crc_ok;
  logic [11:0]           seq_diff;
  logic [PW-1:0]         used_d;
  logic                  unused_inputs;

  assign accept        = s_axis_tvalid && tready_q;
  assign rd_word       = mem[rd_ptr_q[AW-1:0]];
  assign seq_diff      = next_seq_q - seq_q;
  assign unused_inputs = ^{s_axis_tkeep, s_axis_tuser};

  always_comb begin
    state_d         = state_q;
    seq_d           = seq_q;
    next_seq_d      = next_seq_q;
    nak_sched_d     = nak_sched_q;
    crc_d           = crc_q;
    hold_d          = hold_q;
    hold_vld_d      = hold_vld_q;
    wr_ptr_d        = wr_ptr_q;
    commit_ptr_d    = commit_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    m_valid_d       = m_valid_q;
    m_data_d        = m_data_q;
    m_last_d        = m_last_q;
    ack_d           = ack_q;
    ack_seq_d       = ack_seq_q;
    ack_vld_d       = 1'b0;
    crc_err_d       = 1'b0;
    seq_err_d       = 1'b0;
    wr_en           = 1'b0;
    wr_word         = {1'b0, hold_q};
    frame_end       = 1'b0;
    frame_malformed = 1'b0;
    frame_user      = 1'b0;
    crc_ok          = 1'b0;
    used_d          = '0;

    case (state_q)
      ST_HDR: begin
        if (accept) begin
          crc_d      = crc_step(CRC_INIT, s_axis_tdata, 2);
          seq_d      = s_axis_tdata[11:0];
          hold_vld_d = 1'b0;
          if (s_axis_tlast) begin
            frame_end       = 1'b1;
            frame_malformed = 1'b1;
            frame_user      = s_axis_tuser[0];
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (!s_axis_tlast) begin
            // Each DW waits one beat so the last one can carry tlast.
            crc_d      = crc_step(crc_q, s_axis_tdata, 4);
            hold_d     = s_axis_tdata;
            hold_vld_d = 1'b1;
            if (hold_vld_q) begin
              wr_en    = 1'b1;
              wr_word  = {1'b0, hold_q};
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end else begin
            frame_end       = 1'b1;
            frame_malformed = !hold_vld_q;
            frame_user      = s_axis_tuser[0];
            crc_ok          = (s_axis_tdata[31:0] == ~crc_q);
            state_d         = ST_HDR;
          end
        end
      end
    endcase

    if (frame_end) begin
      wr_ptr_d = commit_ptr_q;
      if (frame_user) begin
        // nullified by the PHY: discard without any link-level response
      end else if (frame_malformed || !crc_ok) begin
        crc_err_d = 1'b1;
        if (!nak_sched_q) begin
          ack_vld_d   = 1'b1;
          ack_d       = 1'b0;
          ack_seq_d   = next_seq_q - 12'd1;
          nak_sched_d = 1'b1;
        end
      end else if (seq_q == next_seq_q) begin
        wr_en        = 1'b1;
        wr_word      = {1'b1, hold_q};
        wr_ptr_d     = wr_ptr_q + 1'b1;
        commit_ptr_d = wr_ptr_q + 1'b1;
        next_seq_d   = next_seq_q + 12'd1;
        ack_vld_d    = 1'b1;
        ack_d        = 1'b1;
        ack_seq_d    = seq_q;
        nak_sched_d  = 1'b0;
      end else if (seq_diff != 12'd0 && seq_diff <= 12'd2048) begin
        ack_vld_d = 1'b1;
        ack_d     = 1'b1;
        ack_seq_d = next_seq_q - 12'd1;
      end else begin
        seq_err_d = 1'b1;
        if (!nak_sched_q) begin
          ack_vld_d   = 1'b1;
          ack_d       = 1'b0;
          ack_seq_d   = next_seq_q - 12'd1;
          nak_sched_d = 1'b1;
        end
      end
    end

    // Output register pulls a word as soon as it is empty or being consumed.
    if (rd_ptr_q != commit_ptr_q && (!m_valid_q || m_axis_tready)) begin
      m_valid_d = 1'b1;
      m_data_d  = rd_word[DATA_WIDTH-1:0];
      m_last_d  = rd_word[DATA_WIDTH];
      rd_ptr_d  = rd_ptr_q + 1'b1;
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end

    used_d   = wr_ptr_d - rd_ptr_d;
    tready_d = (used_d <= USED_MAX);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_HDR;
      seq_q        <= '0;
      next_seq_q   <= '0;
      nak_sched_q  <= 1'b0;
      crc_q        <= '0;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      tready_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
      ack_q        <= 1'b0;
      ack_vld_q    <= 1'b0;
      ack_seq_q    <= '0;
      crc_err_q    <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      next_seq_q   <= next_seq_d;
      nak_sched_q  <= nak_sched_d;
      crc_q        <= crc_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      tready_q     <= tready_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
      ack_q        <= ack_d;
      ack_vld_q    <= ack_vld_d;
      ack_seq_q    <= ack_seq_d;
      crc_err_q    <= crc_err_d;
      seq_err_q    <= seq_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_word;
    end
  end

  assign s_axis_tready  = tready_q;
  assign m_axis_tvalid  = m_valid_q;
  assign m_axis_tdata   = m_data_q;
  assign m_axis_tlast   = m_last_q;
  assign m_axis_tkeep   = {KEEP_WIDTH{m_valid_q}};
  assign m_axis_tuser   = '0;
  assign ack_nack_o     = ack_q;
  assign ack_nack_vld_o = ack_vld_q;
  assign ack_seq_num_o  = ack_seq_q;
  assign crc_err_o      = crc_err_q;
  assign seq_err_o      = seq_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dllp_receive.sv
`default_nettype none
// ============================================================================
// tb_dllp_receive : directed + randomized frames against a frame-level model
//                   of the link receive rules.   Rev 1.0
// ============================================================================
module tb_dllp_receive;

  localparam int DEPTH = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic [0:0]  s_axis_tuser = '0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic [0:0]  m_axis_tuser;
  logic        m_axis_tready = 1'b0;
  logic        ack_nack_o;
  logic        ack_nack_vld_o;
  logic [11:0] ack_seq_num_o;
  logic        crc_err_o;
  logic        seq_err_o;

  dllp_receive #(
    .DATA_WIDTH  (32),
    .KEEP_WIDTH  (4),
    .USER_WIDTH  (1),
    .BUFFER_DEPTH(DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_axis_tready),
    .ack_nack_o    (ack_nack_o),
    .ack_nack_vld_o(ack_nack_vld_o),
    .ack_seq_num_o (ack_seq_num_o),
    .crc_err_o     (crc_err_o),
    .seq_err_o     (seq_err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int errors  = 0;
  int beat_cnt = 0;
  int rdy_mode = 1;  // 0: hold low, 1: hold high, 2: random

  // Reference model state
  int          m_next = 0;
  bit          m_nak  = 1'b0;
  logic [32:0] out_q[$];
  logic [31:0] tlp[$];
  bit          e_vld, e_ack, e_crc, e_serr;
  logic [11:0] e_sn;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output scoreboard plus hold-while-stalled rule
  logic [32:0] mon_word;
  logic [32:0] mon_exp;
  bit          mon_pend = 1'b0;
  always @(negedge clk_i) begin
    if (rst_i) begin
      mon_pend = 1'b0;
    end else begin
      if (mon_pend && !m_axis_tvalid) check("m_valid_dropped", m_axis_tvalid, 1);
      if (m_axis_tvalid) begin
        if (mon_pend) check("m_hold_stable", {m_axis_tlast, m_axis_tdata}, mon_word);
        if (m_axis_tready) begin
          mon_pend = 1'b0;
          check("m_beat_expected", out_q.size() != 0, 1);
          if (out_q.size() != 0) begin
            mon_exp = out_q.pop_front();
            check("m_data_last", {m_axis_tlast, m_axis_tdata}, mon_exp);
            check("m_keep_user", {m_axis_tkeep, m_axis_tuser}, {4'hF, 1'b0});
          end
        end else begin
          mon_pend = 1'b1;
          mon_word = {m_axis_tlast, m_axis_tdata};
        end
      end else begin
        mon_pend = 1'b0;
      end
    end
  end

  task automatic put_beat(input logic [31:0] d, input logic [3:0] k, input bit l, input bit u);
    int guard = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && guard < 2000) begin
      @(negedge clk_i);
      guard++;
    end
    if (!s_axis_tready) begin
      vectors++;
      errors++;
      $display("FAIL s_tready_timeout: observed 0 expected 1");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $fatal(1, "input stalled indefinitely");
    end
    @(negedge clk_i);
    beat_cnt++;
  endtask

  // Frame-end rules applied to the model; commits the frame's TLP words to out_q.
  task automatic predict(input int seq, input bit crc_good, input bit malformed, input bit user);
    int d;
    e_vld = 0; e_ack = 0; e_sn = '0; e_crc = 0; e_serr = 0;
    if (user) return;
    if (!crc_good || malformed) begin
      e_crc = 1;
      if (!m_nak) begin
        e_vld = 1; e_ack = 0; e_sn = 12'((m_next + 4095) % 4096); m_nak = 1;
      end
    end else if (seq == m_next) begin
      e_vld = 1; e_ack = 1; e_sn = 12'(seq);
      for (int i = 0; i < tlp.size(); i++) out_q.push_back({i == tlp.size() - 1, tlp[i]});
      m_next = (m_next + 1) % 4096;
      m_nak  = 0;
    end else begin
      d = (m_next - seq + 4096) % 4096;
      if (d >= 1 && d <= 2048) begin
        e_vld = 1; e_ack = 1; e_sn = 12'((m_next + 4095) % 4096);
      end else begin
        e_serr = 1;
        if (!m_nak) begin
          e_vld = 1; e_ack = 0; e_sn = 12'((m_next + 4095) % 4096); m_nak = 1;
        end
      end
    end
  endtask

  task automatic send_frame(input int seq, input int ndw, input bit corrupt, input bit user,
                            input bit hdr_last, input bit chk_lat);
    logic [7:0]  bytes[$];
    logic [31:0] crc;
    logic [31:0] w;
    logic [11:0] s12;
    s12 = 12'(seq);
    tlp.delete();
    bytes.push_back(s12[7:0]);
    bytes.push_back({4'h0, s12[11:8]});
    for (int i = 0; i < ndw; i++) begin
      w = $urandom;
      tlp.push_back(w);
      for (int b = 0; b < 4; b++) bytes.push_back(w[8*b +: 8]);
    end
    crc = 32'hFFFF_FFFF;
    foreach (bytes[i]) begin
      crc = crc ^ {24'd0, bytes[i]};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
    end
    crc = ~crc;
    if (corrupt) crc = crc ^ (32'h1 << $urandom_range(31, 0));

    put_beat({20'h0, s12}, 4'b0011, hdr_last, hdr_last ? user : 1'b0);
    if (!hdr_last) begin
      foreach (tlp[i]) put_beat(tlp[i], 4'hF, 1'b0, 1'b0);
      put_beat(crc, 4'hF, 1'b1, user);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;

    predict(seq, !corrupt, hdr_last || ndw == 0, user);
    check("ack_nack_vld", ack_nack_vld_o, e_vld);
    check("crc_err", crc_err_o, e_crc);
    check("seq_err", seq_err_o, e_serr);
    if (e_vld) begin
      check("ack_nack", ack_nack_o, e_ack);
      check("ack_seq_num", ack_seq_num_o, e_sn);
    end
    if (chk_lat) begin
      check("lat_n1_mvalid", m_axis_tvalid, 0);
      @(negedge clk_i);
      check("lat_n2_mvalid", m_axis_tvalid, 1);
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((out_q.size() != 0 || m_axis_tvalid) && g < 1000) begin
      @(negedge clk_i);
      g++;
    end
    check("drain_empty", out_q.size(), 0);
  endtask

  initial begin
    int base;
    int kind;
    int sq;
    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_outputs", {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tkeep,
                          ack_nack_o, ack_nack_vld_o, ack_seq_num_o, crc_err_o, seq_err_o}, 0);
    rst_i = 1'b0;
    check("tready_at_release", s_axis_tready, 0);
    @(negedge clk_i);
    check("tready_after_release", s_axis_tready, 1);

    // LCRC errors, NAK scheduling, recovery and in-order acceptance
    send_frame(0, 4, 1, 0, 0, 0);
    send_frame(0, 4, 1, 0, 0, 0);
    send_frame(0, 4, 0, 0, 0, 1);
    for (int s = 1; s <= 5; s++) send_frame(s, 4, 0, 0, 0, 0);
    send_frame(3, 2, 0, 0, 0, 0);
    send_frame(9, 2, 0, 0, 0, 0);
    send_frame(6, 3, 0, 0, 0, 0);
    send_frame(7, 2, 0, 1, 0, 0);
    send_frame(7, 0, 0, 0, 1, 0);
    send_frame(7, 0, 0, 0, 0, 0);
    send_frame(7, 1, 0, 0, 0, 0);
    send_frame(8, 0, 0, 0, 0, 0);
    send_frame(8, 2, 0, 0, 0, 0);
    drain();

    // Back-pressure: output held off until the input side must stall
    rdy_mode = 0;
    repeat (2) @(negedge clk_i);
    base = beat_cnt;
    fork
      begin
        for (int f = 0; f < 6; f++) send_frame(m_next, 3, 0, 0, 0, 0);
      end
      begin
        int g = 0;
        while (s_axis_tready && g < 400) begin
          @(negedge clk_i);
          g++;
        end
        check("bp_tready_drop", s_axis_tready, 0);
        check("bp_beats_before_stall", (beat_cnt - base) >= 24 && (beat_cnt - base) <= 30, 1);
        repeat (20) @(negedge clk_i);
        check("bp_tready_held_low", s_axis_tready, 0);
        rdy_mode = 1;
      end
    join
    drain();

    // Random mix of in-order, duplicate, future, corrupted and nullified frames
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        6:       sq = (m_next - int'($urandom_range(1, 2048)) + 4096) % 4096;
        7:       sq = (m_next + int'($urandom_range(1, 2047))) % 4096;
        default: sq = m_next;
      endcase
      send_frame(sq, int'($urandom_range(1, 6)), kind == 8, kind == 9, 0, 0);
    end
    rdy_mode = 1;
    drain();

    // Sequence wrap 4095 -> 0 and the duplicate/future boundary
    while (m_next != 4095) send_frame(m_next, 1, 0, 0, 0, 0);
    send_frame(4095, 2, 0, 0, 0, 0);
    send_frame(0, 2, 0, 0, 0, 0);
    send_frame((m_next - 2048 + 4096) % 4096, 1, 0, 0, 0, 0);
    send_frame((m_next + 2047) % 4096, 1, 0, 0, 0, 0);
    send_frame(m_next, 1, 0, 0, 0, 0);
    drain();

    // Asynchronous reset in the middle of a frame with output stalled
    rdy_mode = 0;
    repeat (2) @(negedge clk_i);
    send_frame(m_next, 3, 0, 0, 0, 0);
    repeat (3) @(negedge clk_i);
    check("pre_rst_mvalid", m_axis_tvalid, 1);
    put_beat({20'h0, 12'(m_next)}, 4'b0011, 1'b0, 1'b0);
    put_beat($urandom, 4'hF, 1'b0, 1'b0);
    rst_i = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    check("rst_mid_outputs", {s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tkeep,
                              ack_nack_o, ack_nack_vld_o, ack_seq_num_o, crc_err_o, seq_err_o}, 0);
    out_q.delete();
    m_next = 0;
    m_nak  = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    rdy_mode = 1;
    @(negedge clk_i);
    send_frame(0, 2, 0, 0, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
